// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state type, frame geometry and register map for spi_cfg_master.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic WRITE_FLAG = 1'b1;

    localparam logic [ADDR_W-1:0] REG_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] REG_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] REG_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] REG_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] REG_DUTY   = 7'd4;

    // Frame goes out LSB first: write flag, then address, then data.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
        return {data, addr, WRITE_FLAG};
    endfunction

endpackage

// File: rtl/spi_cfg_master_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_REQ requesters; the pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   cand;

    // Scan from the farthest offset down so the nearest request at or after ptr wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                idx = cand[IDX_W-1:0];
            end
        end
        grant      = '0;
        grant[idx] = |req;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: arbitrates register writes and serialises each into a 16-bit SPI frame.
// Define SPI_CFG_SHADOW_EN to keep per-address shadows and skip writes that change nothing.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 4,
    parameter int MAX_ADDR = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cs_n,
    output logic                      sclk,
    output logic                      copi,
    output logic                      busy,
    output logic                      err_addr,
    output logic                      skip
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam logic [PH_W-1:0] DIV_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(CS_GAP - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_q, bit_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               cs_n_q, cs_n_d, sclk_q, sclk_d, copi_q, copi_d;
    logic               busy_q, busy_d, err_q, err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   g_idx;
    logic               advance;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_data;
    logic               addr_ok;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant),
        .idx     (g_idx)
    );

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_idx == IDX_W'(i)) begin
                g_addr = req_addr[i*ADDR_W +: ADDR_W];
                g_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Every grant consumes the request, whether it becomes a frame, an error or a skip.
    assign addr_ok   = (g_addr <= ADDR_W'(MAX_ADDR));
    assign advance   = rst_n && (state_q == IDLE) && (|req_valid);
    assign req_ready = advance ? grant : '0;

`ifdef SPI_CFG_SHADOW_EN
    localparam int SH_W = (MAX_ADDR > 0) ? $clog2(MAX_ADDR + 1) : 1;
    logic [DATA_W-1:0] shadow_q [MAX_ADDR+1];
    logic [DATA_W-1:0] shadow_d [MAX_ADDR+1];
    logic [SH_W-1:0]   sh_idx;
    logic              redundant, skip_q, skip_d;

    assign sh_idx    = g_addr[SH_W-1:0];
    assign redundant = addr_ok && (shadow_q[sh_idx] == g_data);
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        err_d   = 1'b0;
`ifdef SPI_CFG_SHADOW_EN
        skip_d   = 1'b0;
        shadow_d = shadow_q;
`endif
        case (state_q)
            IDLE: begin
                if (advance) begin
                    if (!addr_ok) begin
                        err_d = 1'b1;
                    end
`ifdef SPI_CFG_SHADOW_EN
                    else if (redundant) begin
                        skip_d = 1'b1;
                    end
`endif
                    else begin
`ifdef SPI_CFG_SHADOW_EN
                        shadow_d[sh_idx] = g_data;
`endif
                        state_d = SHIFT;
                        shift_d = build_frame(g_addr, g_data);
                        copi_d  = shift_d[0];
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        bit_d   = '0;
                        ph_d    = '0;
                    end
                end
            end
            SHIFT: begin
                if (ph_q == DIV_LAST) begin
                    ph_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = HOLD;
                            copi_d  = 1'b0;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = shift_q >> 1;
                            copi_d  = shift_q[1];
                        end
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            HOLD: begin
                if (ph_q == DIV_LAST) begin
                    ph_d    = '0;
                    cs_n_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            GAP: begin
                if (ph_q == GAP_LAST) begin
                    ph_d    = '0;
                    state_d = IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

`ifdef SPI_CFG_SHADOW_EN
    // Shadows reset to 0x00 to match the peripheral's own reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= 1'b0;
            for (int a = 0; a <= MAX_ADDR; a++) begin
                shadow_q[a] <= '0;
            end
        end else begin
            skip_q   <= skip_d;
            shadow_q <= shadow_d;
        end
    end
    assign skip = skip_q;
`else
    assign skip = 1'b0;
`endif

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign copi     = copi_q;
    assign busy     = busy_q;
    assign err_addr = err_q;

endmodule
